// File: rtl/lc3_pkg.sv
// Shared LC-3 operate-unit definitions: opcodes, ALU function codes, FSM states.
// Latency: n/a (constants, types and a pure helper function only).
// Backpressure: n/a.
package lc3_pkg;

  // LC-3 opcodes handled by the operate controller
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  // ALUK encodings understood by the external 3-function ALU
  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_ZERO = 2'b11;

  // Condition codes after reset: Z set, as if the last result was zero
  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    WB     = 2'b11
  } state_e;

  // {N,Z,P} from the sign bit and a zero flag of a result
  function automatic logic [2:0] nzp_flags(input logic msb, input logic is_zero);
    return {msb, is_zero, !msb && !is_zero};
  endfunction

endpackage

// File: rtl/lc3_regfile.sv
// General register file: two combinational read ports, one debug read port, one write port.
// Latency: reads are combinational; a write is visible after the clock edge that performs it.
// Backpressure: none; writes are accepted every cycle that we is high.
module lc3_regfile
  import lc3_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int REG_NUM   = 8,
  parameter int AW        = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        ra_addr,
  output logic [DATA_SIZE-1:0] ra_data,
  input  logic [AW-1:0]        rb_addr,
  output logic [DATA_SIZE-1:0] rb_data,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DATA_SIZE-1:0] dbg_data,
  input  logic                 we,
  input  logic [AW-1:0]        wa,
  input  logic [DATA_SIZE-1:0] wd
);

  logic [DATA_SIZE-1:0] regs_q [REG_NUM];
  logic [DATA_SIZE-1:0] regs_d [REG_NUM];

  // Next register contents: hold, except the single written entry
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[wa] = wd;
    end
  end

  // Register storage with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra_data  = regs_q[ra_addr];
  assign rb_data  = regs_q[rb_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/lc3_operate_ctrl.sv
// Issue/control for LC-3 ADD/AND/NOT: decode, drive the external ALU, write back, update NZP.
// Latency: accept at cycle 0, done pulse in cycle 3; illegal opcode pulses illegal in cycle 2.
// Backpressure: instr_ready is high only in IDLE, so one instruction is in flight at a time.
module lc3_operate_ctrl
  import lc3_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int REG_NUM   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [15:0]          instr,
  output logic                 instr_ready,
  output logic [DATA_SIZE-1:0] alu_op_a,
  output logic [DATA_SIZE-1:0] alu_op_b,
  output logic [1:0]           aluk,
  input  logic [DATA_SIZE-1:0] alu_y,
  input  logic                 alu_cyo,
  output logic                 done,
  output logic                 illegal,
  output logic [2:0]           nzp,
  input  logic [2:0]           dbg_addr,
  output logic [DATA_SIZE-1:0] dbg_data
);

  localparam int MSB = DATA_SIZE - 1;

  state_e               state_q, state_d;
  logic [15:0]          instr_q, instr_d;
  logic [DATA_SIZE-1:0] op_a_q, op_a_d;
  logic [DATA_SIZE-1:0] op_b_q, op_b_d;
  logic [DATA_SIZE-1:0] result_q, result_d;
  logic                 cyo_q, cyo_d;
  logic [1:0]           aluk_sel_q, aluk_sel_d;
  logic [2:0]           nzp_q, nzp_d;
  logic                 illegal_q, illegal_d;

  // Instruction fields of the latched word
  logic [3:0]           opcode;
  logic [2:0]           dr;
  logic [2:0]           sr1;
  logic [2:0]           sr2;
  logic                 imm_sel;
  logic [DATA_SIZE-1:0] imm_sext;
  logic [DATA_SIZE-1:0] rd_a;
  logic [DATA_SIZE-1:0] rd_b;
  logic                 wb_en;

  assign opcode   = instr_q[15:12];
  assign dr       = instr_q[11:9];
  assign sr1      = instr_q[8:6];
  assign sr2      = instr_q[2:0];
  assign imm_sel  = instr_q[5];
  assign imm_sext = {{(DATA_SIZE-5){instr_q[4]}}, instr_q[4:0]};

  // Carry-out is kept with the result for observability only; nothing consumes it.
  logic unused_cyo;
  assign unused_cyo = cyo_q;

  lc3_regfile #(
    .DATA_SIZE (DATA_SIZE),
    .REG_NUM   (REG_NUM)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (sr1),
    .ra_data  (rd_a),
    .rb_addr  (sr2),
    .rb_data  (rd_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_en),
    .wa       (dr),
    .wd       (result_q)
  );

  // Next-state and datapath register updates for the four-phase sequence
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    result_d   = result_q;
    cyo_d      = cyo_q;
    aluk_sel_d = aluk_sel_q;
    nzp_d      = nzp_q;
    illegal_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // Sources are sampled here, so DR==SRx sees the pre-writeback value.
        case (opcode)
          OP_ADD: begin
            op_a_d     = rd_a;
            op_b_d     = imm_sel ? imm_sext : rd_b;
            aluk_sel_d = ALUK_ADD;
            state_d    = EXEC;
          end
          OP_AND: begin
            op_a_d     = rd_a;
            op_b_d     = imm_sel ? imm_sext : rd_b;
            aluk_sel_d = ALUK_AND;
            state_d    = EXEC;
          end
          OP_NOT: begin
            op_a_d     = rd_a;
            op_b_d     = '0;
            aluk_sel_d = ALUK_NOT;
            state_d    = EXEC;
          end
          default: begin
            illegal_d = 1'b1;
            state_d   = IDLE;
          end
        endcase
      end
      EXEC: begin
        result_d = alu_y;
        cyo_d    = alu_cyo;
        state_d  = WB;
      end
      WB: begin
        nzp_d   = nzp_flags(result_q[MSB], result_q == '0);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      instr_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      cyo_q      <= 1'b0;
      aluk_sel_q <= ALUK_ZERO;
      nzp_q      <= NZP_RESET;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      result_q   <= result_d;
      cyo_q      <= cyo_d;
      aluk_sel_q <= aluk_sel_d;
      nzp_q      <= nzp_d;
      illegal_q  <= illegal_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign wb_en       = (state_q == WB);
  assign done        = wb_en;
  assign aluk        = (state_q == EXEC) ? aluk_sel_q : ALUK_ZERO;
  assign alu_op_a    = op_a_q;
  assign alu_op_b    = op_b_q;
  assign illegal     = illegal_q;
  assign nzp         = nzp_q;

endmodule

// File: tb/tb_lc3_operate_ctrl.sv
// Directed bench for lc3_operate_ctrl with a behavioural model of the external ALU.
// Latency: checks cycle-exact accept/exec/writeback timing against hand-computed vectors.
// Backpressure: exercises instr_valid held high while the block is busy.
module tb_lc3_operate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_op_a;
  logic [15:0] alu_op_b;
  logic [1:0]  aluk;
  logic [15:0] alu_y;
  logic        alu_cyo;
  logic        done;
  logic        illegal;
  logic [2:0]  nzp;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] mreg [8];

  lc3_operate_ctrl #(.DATA_SIZE(16), .REG_NUM(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_op_a    (alu_op_a),
    .alu_op_b    (alu_op_b),
    .aluk        (aluk),
    .alu_y       (alu_y),
    .alu_cyo     (alu_cyo),
    .done        (done),
    .illegal     (illegal),
    .nzp         (nzp),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: 00 ADD, 01 AND, 10 NOT, 11 zero
  always_comb begin
    {alu_cyo, alu_y} = 17'h0;
    case (aluk)
      2'b00:   {alu_cyo, alu_y} = {1'b0, alu_op_a} + {1'b0, alu_op_b};
      2'b01:   alu_y = alu_op_a & alu_op_b;
      2'b10:   alu_y = ~alu_op_a;
      default: alu_y = 16'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_rdy_wait"}, {15'h0, instr_ready}, 16'h1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      chk($sformatf("%s_R%0d", tag, i), dbg_data, mreg[i]);
    end
  endtask

  // Issue one legal instruction and follow it cycle by cycle through writeback
  task automatic run_op(input string tag, input logic [15:0] w, input logic [1:0] ak,
                        input logic [2:0] dr, input logic [15:0] val, input logic [2:0] nz);
    wait_ready(tag);
    instr = w;
    instr_valid = 1'b1;
    tick();                                   // cycle 1: DECODE
    instr_valid = 1'b0;
    instr = 16'hFFFF;
    chk({tag, "_c1_rdy"}, {15'h0, instr_ready}, 16'h0);
    tick();                                   // cycle 2: EXEC
    chk({tag, "_c2_aluk"}, {14'h0, aluk}, {14'h0, ak});
    chk({tag, "_c2_done"}, {15'h0, done}, 16'h0);
    tick();                                   // cycle 3: WB
    chk({tag, "_c3_done"}, {15'h0, done}, 16'h1);
    chk({tag, "_c3_aluk"}, {14'h0, aluk}, 16'h3);
    dbg_addr = dr;
    #1;
    chk({tag, "_c3_dbg_old"}, dbg_data, mreg[dr]);
    tick();                                   // cycle 4: IDLE
    mreg[dr] = val;
    chk({tag, "_c4_done"}, {15'h0, done}, 16'h0);
    chk({tag, "_c4_rdy"}, {15'h0, instr_ready}, 16'h1);
    chk({tag, "_dr"}, dbg_data, val);
    chk({tag, "_nzp"}, {13'h0, nzp}, {13'h0, nz});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = 16'h0;
    dbg_addr = 3'd0;
    tick();
    tick();

    // Reset state
    chk("rst_nzp", {13'h0, nzp}, 16'h2);
    chk("rst_aluk", {14'h0, aluk}, 16'h3);
    chk("rst_done", {15'h0, done}, 16'h0);
    chk("rst_illegal", {15'h0, illegal}, 16'h0);
    chk("rst_op_a", alu_op_a, 16'h0);
    chk("rst_op_b", alu_op_b, 16'h0);
    check_regs("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_rdy", {15'h0, instr_ready}, 16'h1);

    // Arithmetic/logic vectors
    run_op("add_imm5",  16'h1225, 2'b00, 3'd1, 16'h0005, 3'b001);
    run_op("add_immn16",16'h1430, 2'b00, 3'd2, 16'hFFF0, 3'b100);
    run_op("not_r2",    16'h96BF, 2'b10, 3'd3, 16'h000F, 3'b001);
    run_op("and_r2r3",  16'h5883, 2'b01, 3'd4, 16'h0000, 3'b010);
    run_op("add_r1r1",  16'h1241, 2'b00, 3'd1, 16'h000A, 3'b001);
    run_op("add_wrap",  16'h1A82, 2'b00, 3'd5, 16'hFFE0, 3'b100);

    // Illegal opcode: pulse in cycle 2, ready again in cycle 2, no state change
    wait_ready("ill");
    instr = 16'h0000;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("ill_c1_illegal", {15'h0, illegal}, 16'h0);
    chk("ill_c1_rdy", {15'h0, instr_ready}, 16'h0);
    tick();
    chk("ill_c2_illegal", {15'h0, illegal}, 16'h1);
    chk("ill_c2_rdy", {15'h0, instr_ready}, 16'h1);
    chk("ill_c2_done", {15'h0, done}, 16'h0);
    tick();
    chk("ill_c3_illegal", {15'h0, illegal}, 16'h0);
    chk("ill_c3_done", {15'h0, done}, 16'h0);
    chk("ill_nzp", {13'h0, nzp}, 16'h4);
    check_regs("ill");

    // instr_valid held high: second word only accepted in cycle 4
    wait_ready("b2b");
    instr = 16'h1E21;                         // ADD R7,R0,#1
    instr_valid = 1'b1;
    tick();
    instr = 16'h1FE3;                         // ADD R7,R7,#3
    chk("b2b_c1_rdy", {15'h0, instr_ready}, 16'h0);
    tick();
    chk("b2b_c2_rdy", {15'h0, instr_ready}, 16'h0);
    tick();
    chk("b2b_c3_rdy", {15'h0, instr_ready}, 16'h0);
    chk("b2b_c3_done", {15'h0, done}, 16'h1);
    tick();
    chk("b2b_c4_rdy", {15'h0, instr_ready}, 16'h1);
    dbg_addr = 3'd7;
    #1;
    chk("b2b_first_r7", dbg_data, 16'h0001);
    tick();
    instr_valid = 1'b0;
    chk("b2b_2nd_c1_rdy", {15'h0, instr_ready}, 16'h0);
    tick();
    tick();
    chk("b2b_2nd_c3_done", {15'h0, done}, 16'h1);
    tick();
    mreg[7] = 16'h0004;
    chk("b2b_second_r7", dbg_data, 16'h0004);
    chk("b2b_nzp", {13'h0, nzp}, 16'h1);

    // Reset during EXEC: instruction dropped, everything back to reset values
    wait_ready("rstx");
    instr = 16'h1225;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    chk("rstx_c2_aluk", {14'h0, aluk}, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstx_aluk", {14'h0, aluk}, 16'h3);
    chk("rstx_nzp", {13'h0, nzp}, 16'h2);
    chk("rstx_done", {15'h0, done}, 16'h0);
    tick();
    tick();
    rst_n = 1'b1;
    dn = 0;
    repeat (6) begin
      tick();
      if (done) dn++;
    end
    chk("rstx_done_cnt", 16'(dn), 16'h0);
    chk("rstx_nzp_after", {13'h0, nzp}, 16'h2);
    for (int i = 0; i < 8; i++) mreg[i] = 16'h0;
    check_regs("rstx");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
